seven_seg_status_scroller: RTL and testbench

Parametrised status display driver for the DRFM front panel. It maps the one-hot controller state to a per-state text message on NUM_DIGITS seven-segment digits. Messages longer than the display scroll left with wrap-around, and the error message blinks. It sits between the top-level control FSM and the board's active-low seven-segment pins, and supersedes the fixed six-digit combinational status decoder.

---
 rtl/seven_seg_pkg.sv | 119 +++++++++++
 rtl/seven_seg_msg_rom.sv | 14 +
 rtl/seven_seg_status_scroller.sv | 123 ++++++++++++
 tb/tb_seven_seg_status_scroller.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Character codes, glyph table and per-state message ROM for the
// front-panel status scroller.
package seven_seg_pkg;

    typedef enum logic [3:0] {
        CH_BLANK, CH_DOT, CH_A, CH_C, CH_D, CH_E, CH_L,
        CH_O, CH_P, CH_R, CH_S, CH_T, CH_Y
    } char_e;

    localparam int MSG_MAX = 9;
    localparam int IDX_W   = 8;

    localparam logic [3:0] ST_WAIT    = 4'b0000;
    localparam logic [3:0] ST_DELAY   = 4'b0001;
    localparam logic [3:0] ST_SCALE   = 4'b0010;
    localparam logic [3:0] ST_LOAD    = 4'b0100;
    localparam logic [3:0] ST_DOPPLER = 4'b1000;

    function automatic logic [7:0] char_glyph(input char_e c);
        logic [7:0] g;
        case (c)
            CH_DOT:  g = 8'h80;
            CH_A:    g = 8'h77;
            CH_C:    g = 8'h39;
            CH_D:    g = 8'h5E;
            CH_E:    g = 8'h79;
            CH_L:    g = 8'h38;
            CH_O:    g = 8'h3F;
            CH_P:    g = 8'h73;
            CH_R:    g = 8'h31;
            CH_S:    g = 8'h6D;
            CH_T:    g = 8'h78;
            CH_Y:    g = 8'h6E;
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    function automatic logic is_error(input logic [3:0] st);
        return !(st == ST_WAIT || st == ST_DELAY || st == ST_SCALE ||
                 st == ST_LOAD || st == ST_DOPPLER);
    endfunction

    function automatic logic [IDX_W-1:0] msg_len(input logic [3:0] st,
                                                 input int unsigned ndig);
        logic [IDX_W-1:0] n;
        case (st)
            ST_WAIT:    n = IDX_W'(ndig);
            ST_LOAD:    n = IDX_W'(9);
            ST_DOPPLER: n = IDX_W'(7);
            default:    n = IDX_W'(6);
        endcase
        return n;
    endfunction

    function automatic char_e msg_char(input logic [3:0] st,
                                       input logic [IDX_W-1:0] idx,
                                       input int unsigned ndig);
        char_e c;
        c = CH_BLANK;
        // Indices past the message end form the trailing blank(s)
        if (idx < msg_len(st, ndig)) begin
            case (st)
                ST_WAIT: c = CH_DOT;
                ST_DELAY:
                    case (idx[3:0])
                        4'd0:    c = CH_D;
                        4'd1:    c = CH_E;
                        4'd2:    c = CH_L;
                        4'd3:    c = CH_A;
                        4'd4:    c = CH_Y;
                        default: c = CH_DOT;
                    endcase
                ST_SCALE:
                    case (idx[3:0])
                        4'd0:    c = CH_S;
                        4'd1:    c = CH_C;
                        4'd2:    c = CH_A;
                        4'd3:    c = CH_L;
                        4'd4:    c = CH_E;
                        default: c = CH_DOT;
                    endcase
                ST_LOAD:
                    case (idx[3:0])
                        4'd0:    c = CH_L;
                        4'd1:    c = CH_O;
                        4'd2:    c = CH_A;
                        4'd3:    c = CH_D;
                        4'd4:    c = CH_BLANK;
                        4'd5:    c = CH_D;
                        4'd6:    c = CH_A;
                        4'd7:    c = CH_T;
                        default: c = CH_A;
                    endcase
                ST_DOPPLER:
                    case (idx[3:0])
                        4'd0:    c = CH_D;
                        4'd1:    c = CH_O;
                        4'd2:    c = CH_P;
                        4'd3:    c = CH_P;
                        4'd4:    c = CH_L;
                        4'd5:    c = CH_E;
                        default: c = CH_R;
                    endcase
                default:
                    case (idx[3:0])
                        4'd0:    c = CH_E;
                        4'd1:    c = CH_R;
                        4'd2:    c = CH_R;
                        4'd3:    c = CH_O;
                        4'd4:    c = CH_R;
                        default: c = CH_DOT;
                    endcase
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/seven_seg_msg_rom.sv
// One digit's glyph lookup: (state, virtual index) -> active-high glyph.
module seven_seg_msg_rom
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic [3:0]       state,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       glyph
);

    assign glyph = char_glyph(msg_char(state, idx, NUM_DIGITS));

endmodule

// File: rtl/seven_seg_status_scroller.sv
// Status display driver: per-state message on NUM_DIGITS seven-segment
// digits, scrolling long messages and blinking the error message.
module seven_seg_status_scroller
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCROLL_DIV = 12_500_000,
    parameter int BLINK_DIV  = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              state,
    input  logic                    hold,
    output logic [8*NUM_DIGITS-1:0] seg
);

    localparam int OFF_W = $clog2(MSG_MAX + 1);
    localparam int SC_W  = $clog2(SCROLL_DIV);
    localparam int BL_W  = $clog2(BLINK_DIV);
    localparam logic [7:0] DARK = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [3:0]              state_q, state_d;
    logic                    force_q, force_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [SC_W-1:0]         sc_q, sc_d;
    logic [BL_W-1:0]         bl_q, bl_d;
    logic                    on_q, on_d;
    logic [8*NUM_DIGITS-1:0] seg_q, seg_d;

    logic             load;
    logic             err;
    logic             scrolls;
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] period;

    assign load    = force_q || (state != state_q);
    assign state_d = state;
    assign err     = is_error(state_d);
    assign len     = msg_len(state_d, NUM_DIGITS);
    assign period  = len + IDX_W'(1);
    assign scrolls = len > IDX_W'(NUM_DIGITS);

    always_comb begin
        force_d = 1'b0;
        off_d   = off_q;
        sc_d    = sc_q;
        bl_d    = bl_q;
        on_d    = on_q;
        if (load) begin
            off_d = '0;
            sc_d  = '0;
            bl_d  = '0;
            on_d  = 1'b1;
        end else begin
            if (scrolls && !hold) begin
                if (sc_q == SC_W'(SCROLL_DIV - 1)) begin
                    sc_d  = '0;
                    off_d = (IDX_W'(off_q) == period - IDX_W'(1)) ?
                            '0 : off_q + OFF_W'(1);
                end else begin
                    sc_d = sc_q + SC_W'(1);
                end
            end
            if (err) begin
                if (bl_q == BL_W'(BLINK_DIV - 1)) begin
                    bl_d = '0;
                    on_d = !on_q;
                end else begin
                    bl_d = bl_q + BL_W'(1);
                end
            end else begin
                bl_d = '0;
                on_d = 1'b1;
            end
        end
    end

    // Output is built from next-state values so a change shows in one edge
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        logic [IDX_W:0]   raw;
        logic [IDX_W-1:0] vidx;
        logic [7:0]       gl;

        assign raw  = (IDX_W+1)'(off_d) + (IDX_W+1)'(NUM_DIGITS - 1 - k);
        assign vidx = (scrolls && raw >= {1'b0, period}) ?
                      IDX_W'(raw - {1'b0, period}) : IDX_W'(raw);

        seven_seg_msg_rom #(
            .NUM_DIGITS(NUM_DIGITS)
        ) u_rom (
            .state(state_d),
            .idx  (vidx),
            .glyph(gl)
        );

        assign seg_d[8*k +: 8] = !on_d ? DARK :
                                 (ACTIVE_LOW ? ~gl : gl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT;
            force_q <= 1'b1;
            off_q   <= '0;
            sc_q    <= '0;
            bl_q    <= '0;
            on_q    <= 1'b1;
            seg_q   <= {NUM_DIGITS{DARK}};
        end else begin
            state_q <= state_d;
            force_q <= force_d;
            off_q   <= off_d;
            sc_q    <= sc_d;
            bl_q    <= bl_d;
            on_q    <= on_d;
            seg_q   <= seg_d;
        end
    end

    assign seg = seg_q;

endmodule

// File: tb/tb_seven_seg_status_scroller.sv
// Scoreboard bench: driver queues hand-computed display words per cycle,
// monitor pops and compares both a 6-digit and an 8-digit instance.
module tb_seven_seg_status_scroller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  st;
    logic [3:0]  st8;
    logic        hold;
    logic [47:0] seg6;
    logic [63:0] seg8;

    int checks   = 0;
    int failures = 0;

    localparam logic [47:0] ALL6    = 48'hFFFF_FFFF_FFFF;
    localparam logic [63:0] ALL8    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [47:0] W_DELAY = 48'hA186_C788_917F;
    localparam logic [47:0] W_DOP0  = 48'hA1C0_8C8C_C786;
    localparam logic [47:0] W_DOP1  = 48'hC08C_8CC7_86CE;
    localparam logic [47:0] W_ERR   = 48'h86CE_CEC0_CE7F;
    localparam logic [47:0] W_WAIT  = 48'h7F7F_7F7F_7F7F;
    localparam logic [63:0] W8_DOP  = 64'hA1C0_8C8C_C786_CEFF;
    localparam logic [47:0] LOADW [10] = '{
        48'hC7C0_88A1_FFA1, 48'hC088_A1FF_A188,
        48'h88A1_FFA1_8887, 48'hA1FF_A188_8788,
        48'hFFA1_8887_88FF, 48'hA188_8788_FFC7,
        48'h8887_88FF_C7C0, 48'h8788_FFC7_C088,
        48'h88FF_C7C0_88A1, 48'hFFC7_C088_A1FF
    };

    typedef struct {
        logic [47:0] e6;
        logic [63:0] e8;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    int pre;
    int off;

    seven_seg_status_scroller #(
        .NUM_DIGITS(6), .SCROLL_DIV(4), .BLINK_DIV(3), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .state(st), .hold(hold), .seg(seg6)
    );

    seven_seg_status_scroller #(
        .NUM_DIGITS(8), .SCROLL_DIV(4), .BLINK_DIV(3), .ACTIVE_LOW(1'b1)
    ) dut8 (
        .clk(clk), .rst(rst), .state(st8), .hold(hold), .seg(seg8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            cur = q.pop_front();
            checks++;
            if (seg6 !== cur.e6) begin
                failures++;
                $display("FAIL %s seg6 got %h want %h", cur.nm, seg6, cur.e6);
            end
            checks++;
            if (seg8 !== cur.e8) begin
                failures++;
                $display("FAIL %s seg8 got %h want %h", cur.nm, seg8, cur.e8);
            end
        end
    end

    task automatic drive(input logic r, input logic [3:0] s, input logic h,
                         input logic [47:0] e, input string nm);
        exp_t x;
        @(negedge clk);
        rst  = r;
        st   = s;
        hold = h;
        x.e6 = e;
        x.e8 = r ? ALL8 : W8_DOP;
        x.nm = nm;
        q.push_back(x);
    endtask

    task automatic load_cyc(input logic h, input bit entry);
        if (entry) begin
            pre = 0;
            off = 0;
        end else if (!h) begin
            if (pre == 3) begin
                pre = 0;
                off = (off + 1) % 10;
            end else begin
                pre++;
            end
        end
        drive(1'b0, 4'b0100, h, LOADW[off], $sformatf("load_off%0d", off));
    endtask

    initial begin
        rst  = 1'b1;
        st   = 4'b0001;
        st8  = 4'b1000;
        hold = 1'b0;

        repeat (3) drive(1'b1, 4'b0001, 1'b0, ALL6, "reset");
        repeat (3) drive(1'b0, 4'b0001, 1'b0, W_DELAY, "delay");

        load_cyc(1'b0, 1'b1);
        repeat (52) load_cyc(1'b0, 1'b0);

        // Entry with hold high: state change still restarts everything
        drive(1'b0, 4'b1000, 1'b1, W_DOP0, "dop_entry");
        repeat (3) drive(1'b0, 4'b1000, 1'b0, W_DOP0, "dop_off0");
        drive(1'b0, 4'b1000, 1'b0, W_DOP1, "dop_off1");

        for (int i = 0; i < 12; i++)
            drive(1'b0, 4'b0011, 1'b0,
                  ((i / 3) % 2 == 0) ? W_ERR : ALL6,
                  $sformatf("err_c%0d", i));

        repeat (6) drive(1'b0, 4'b0000, 1'b0, W_WAIT, "wait");

        load_cyc(1'b0, 1'b1);
        repeat (6) load_cyc(1'b0, 1'b0);
        repeat (20) load_cyc(1'b1, 1'b0);
        repeat (10) load_cyc(1'b0, 1'b0);

        repeat (2) drive(1'b1, 4'b0000, 1'b0, ALL6, "reset2");
        repeat (3) drive(1'b0, 4'b0000, 1'b0, W_WAIT, "wait_after_reset");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
